beta_if_stage: RTL and testbench

Instruction fetch stage: the producer side of the fetch-to-decode instruction interface. It owns the program counter and runs the instruction-memory request/grant/response handshake. It presents one instruction at a time to the decode stage with a single-cycle new-instruction pulse, then holds it until the pipe asks for the next one. It sits at the head of the pipe, between instruction memory and the decode stage, and takes jump/branch redirects from the execute stage.

---
 rtl/beta_if_stage.sv | 102 ++++++++++
 tb/tb_beta_if_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_if_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/gnt/rvalid handshake
// and presents one instruction at a time to decode until it asks for the next.
//
// state | meaning
// BOOT  | reset state, no request outstanding
// REQ   | request raised at the current PC, waiting for grant
// WAIT  | granted, waiting for response data
// VALID | instruction presented to decode, waiting for if_next_i
module beta_if_stage #(
    parameter int unsigned          DataWidth  = 32,
    parameter logic [DataWidth-1:0] BootAddr   = 32'h0000_0000,
    parameter bit                   Compressed = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    output logic                 if_imem_req_o,
    output logic [DataWidth-1:0] if_imem_addr_o,
    input  logic                 if_imem_gnt_i,
    input  logic                 if_imem_rvalid_i,
    input  logic [31:0]          if_imem_rdata_i,
    input  logic                 if_imem_err_i,
    input  logic                 if_next_i,
    input  logic                 if_jump_en_i,
    input  logic [DataWidth-1:0] if_jump_target_i,
    output logic [31:0]          if_instr_o,
    output logic                 if_new_instr_o,
    output logic [DataWidth-1:0] if_pc_o,
    output logic                 if_fetch_err_o,
    output logic                 if_stage_busy_o
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    localparam logic [31:0]          NOP        = 32'h0000_0013;
    localparam logic [DataWidth-1:0] PC_STEP    = Compressed ? DataWidth'(2) : DataWidth'(4);
    localparam logic [DataWidth-1:0] ALIGN_MASK = {{(DataWidth-2){1'b1}}, 2'b00};

    logic [1:0]           state_q;
    logic [DataWidth-1:0] pc_q;
    logic [DataWidth-1:0] instr_pc_q;
    logic [31:0]          instr_q;
    logic                 new_instr_q;
    logic                 fetch_err_q;
    logic [DataWidth-1:0] pc_next;

    always_comb begin
        pc_next = pc_q + PC_STEP;
        if (if_jump_en_i) begin
            pc_next = if_jump_target_i & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_BOOT;
            pc_q        <= BootAddr;
            instr_pc_q  <= BootAddr;
            instr_q     <= NOP;
            new_instr_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            new_instr_q <= 1'b0;
            case (state_q)
                ST_BOOT: state_q <= ST_REQ;
                ST_REQ: begin
                    if (if_imem_gnt_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (if_imem_rvalid_i) begin
                        state_q     <= ST_VALID;
                        new_instr_q <= 1'b1;
                        instr_pc_q  <= pc_q;
                        // Errored fetches present a NOP so decode never sees garbage.
                        instr_q     <= if_imem_err_i ? NOP : if_imem_rdata_i;
                        fetch_err_q <= if_imem_err_i;
                    end
                end
                ST_VALID: begin
                    if (if_next_i) begin
                        state_q <= ST_REQ;
                        pc_q    <= pc_next;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign if_imem_req_o   = (state_q == ST_REQ);
    assign if_imem_addr_o  = pc_q;
    assign if_instr_o      = instr_q;
    assign if_new_instr_o  = new_instr_q;
    assign if_pc_o         = instr_pc_q;
    assign if_fetch_err_o  = fetch_err_q;
    assign if_stage_busy_o = (state_q != ST_VALID);

endmodule

// File: tb/tb_beta_if_stage.sv
// Directed plus randomized bench for beta_if_stage; the bench plays instruction
// memory and decode, and predicts each fetch from a simple PC/fetch model.
module tb_beta_if_stage;

    localparam logic [31:0] BOOT = 32'h0000_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_imem_req_o;
    logic [31:0] if_imem_addr_o;
    logic        if_imem_gnt_i;
    logic        if_imem_rvalid_i;
    logic [31:0] if_imem_rdata_i;
    logic        if_imem_err_i;
    logic        if_next_i;
    logic        if_jump_en_i;
    logic [31:0] if_jump_target_i;
    logic [31:0] if_instr_o;
    logic        if_new_instr_o;
    logic [31:0] if_pc_o;
    logic        if_fetch_err_o;
    logic        if_stage_busy_o;

    beta_if_stage #(.DataWidth(32), .BootAddr(BOOT), .Compressed(1'b0)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .if_imem_req_o    (if_imem_req_o),
        .if_imem_addr_o   (if_imem_addr_o),
        .if_imem_gnt_i    (if_imem_gnt_i),
        .if_imem_rvalid_i (if_imem_rvalid_i),
        .if_imem_rdata_i  (if_imem_rdata_i),
        .if_imem_err_i    (if_imem_err_i),
        .if_next_i        (if_next_i),
        .if_jump_en_i     (if_jump_en_i),
        .if_jump_target_i (if_jump_target_i),
        .if_instr_o       (if_instr_o),
        .if_new_instr_o   (if_new_instr_o),
        .if_pc_o          (if_pc_o),
        .if_fetch_err_o   (if_fetch_err_o),
        .if_stage_busy_o  (if_stage_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_cyc;
    int pulse_cyc;
    int prev_pulse;

    // Model state: address of the fetch in flight and the instruction on display.
    logic [31:0] exp_pc;
    logic [31:0] last_instr;
    logic [31:0] last_pc;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        if_imem_gnt_i    = 1'b0;
        if_imem_rvalid_i = 1'b0;
        if_next_i        = 1'b0;
        if_jump_en_i     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   32'(if_imem_req_o),   32'd0);
        chk({tag, "_addr"},  if_imem_addr_o,       BOOT);
        chk({tag, "_pc"},    if_pc_o,              BOOT);
        chk({tag, "_instr"}, if_instr_o,           NOP);
        chk({tag, "_new"},   32'(if_new_instr_o),  32'd0);
        chk({tag, "_err"},   32'(if_fetch_err_o),  32'd0);
        chk({tag, "_busy"},  32'(if_stage_busy_o), 32'd1);
    endtask

    // One complete fetch at exp_pc: gd stall cycles before grant, rd cycles
    // between grant and response. Out-of-state noise is driven on ignored inputs.
    task automatic fetch(input int gd, input int rd, input bit e, input logic [31:0] data);
        int w;
        logic [31:0] exp_i;
        w = 0;
        while (!if_imem_req_o && w < 8) begin
            step();
            w++;
        end
        chk("req_seen", 32'(if_imem_req_o), 32'd1);
        chk("req_addr", if_imem_addr_o, exp_pc);
        req_cyc = cyc;
        for (int i = 0; i < gd; i++) begin
            if_imem_gnt_i    = 1'b0;
            if_imem_rvalid_i = 1'($urandom_range(0, 1));
            if_next_i        = 1'($urandom_range(0, 1));
            if_jump_en_i     = 1'($urandom_range(0, 1));
            if_jump_target_i = $urandom;
            step();
            chk("stall_req",  32'(if_imem_req_o),   32'd1);
            chk("stall_addr", if_imem_addr_o,       exp_pc);
            chk("stall_busy", 32'(if_stage_busy_o), 32'd1);
        end
        quiet();
        if_imem_gnt_i = 1'b1;
        step();
        if_imem_gnt_i = 1'b0;
        chk("wait_req",  32'(if_imem_req_o),   32'd0);
        chk("wait_busy", 32'(if_stage_busy_o), 32'd1);
        for (int i = 0; i < rd; i++) begin
            if_imem_gnt_i    = 1'($urandom_range(0, 1));
            if_next_i        = 1'($urandom_range(0, 1));
            if_jump_en_i     = 1'($urandom_range(0, 1));
            if_jump_target_i = $urandom;
            step();
            chk("wait_req",  32'(if_imem_req_o),   32'd0);
            chk("wait_new",  32'(if_new_instr_o),  32'd0);
            chk("wait_busy", 32'(if_stage_busy_o), 32'd1);
        end
        quiet();
        if_imem_rvalid_i = 1'b1;
        if_imem_err_i    = e;
        if_imem_rdata_i  = data;
        step();
        if_imem_rvalid_i = 1'b0;
        if_imem_err_i    = 1'($urandom_range(0, 1));
        if_imem_rdata_i  = $urandom;
        pulse_cyc = cyc;
        exp_i = e ? NOP : data;
        chk("latency",   32'(pulse_cyc - req_cyc), 32'(gd + rd + 2));
        chk("pulse",     32'(if_new_instr_o),      32'd1);
        chk("instr",     if_instr_o,               exp_i);
        chk("pc",        if_pc_o,                  exp_pc);
        chk("fetch_err", 32'(if_fetch_err_o),      32'(e));
        chk("busy_fall", 32'(if_stage_busy_o),     32'd0);
        last_instr = exp_i;
        last_pc    = exp_pc;
        last_err   = e;
    endtask

    // Hold in VALID for idle cycles, then request the next instruction.
    task automatic advance(input bit jmp, input logic [31:0] tgt, input int idle);
        for (int i = 0; i < idle; i++) begin
            if_next_i        = 1'b0;
            if_jump_en_i     = 1'($urandom_range(0, 1));
            if_imem_gnt_i    = 1'($urandom_range(0, 1));
            if_imem_rvalid_i = 1'($urandom_range(0, 1));
            step();
            chk("hold_new",   32'(if_new_instr_o),  32'd0);
            chk("hold_instr", if_instr_o,           last_instr);
            chk("hold_pc",    if_pc_o,              last_pc);
            chk("hold_err",   32'(if_fetch_err_o),  32'(last_err));
            chk("hold_req",   32'(if_imem_req_o),   32'd0);
            chk("hold_busy",  32'(if_stage_busy_o), 32'd0);
        end
        quiet();
        if_next_i        = 1'b1;
        if_jump_en_i     = jmp;
        if_jump_target_i = tgt;
        step();
        quiet();
        exp_pc = jmp ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
        chk("next_req",   32'(if_imem_req_o),  32'd1);
        chk("next_addr",  if_imem_addr_o,      exp_pc);
        chk("pulse_once", 32'(if_new_instr_o), 32'd0);
    endtask

    initial begin
        rstn_i           = 1'b0;
        if_imem_rdata_i  = 32'h0;
        if_imem_err_i    = 1'b0;
        if_jump_target_i = 32'h0;
        quiet();
        exp_pc = BOOT;

        step();
        step();
        check_reset_values("rst");
        rstn_i = 1'b1;
        chk("boot_req", 32'(if_imem_req_o), 32'd0);
        step();
        chk("first_req",  32'(if_imem_req_o), 32'd1);
        chk("first_addr", if_imem_addr_o,      BOOT);

        // Boot fetch plus three sequential ones, next asserted in each pulse cycle.
        fetch(0, 0, 1'b0, 32'h0000_0093);
        prev_pulse = pulse_cyc;
        for (int i = 0; i < 3; i++) begin
            advance(1'b0, 32'h0, 0);
            fetch(0, 0, 1'b0, $urandom);
            chk("spacing", 32'(pulse_cyc - prev_pulse), 32'd3);
            prev_pulse = pulse_cyc;
        end
        chk("seq_last_pc", last_pc, 32'h0000_010C);

        advance(1'b1, 32'h0000_2003, 2);
        chk("jump_addr", if_imem_addr_o, 32'h0000_2000);
        fetch(0, 0, 1'b0, $urandom);

        advance(1'b0, 32'h0, 1);
        fetch(3, 2, 1'b0, $urandom);

        advance(1'b0, 32'h0, 0);
        fetch(1, 0, 1'b1, $urandom);
        advance(1'b0, 32'h0, 1);
        fetch(0, 1, 1'b0, $urandom);

        for (int i = 0; i < 25; i++) begin
            advance($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2));
            fetch($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0, $urandom);
        end

        // Leave an errored fetch on display, then reset mid-WAIT.
        advance(1'b1, 32'h0000_4000, 0);
        fetch(0, 0, 1'b1, $urandom);
        advance(1'b0, 32'h0, 0);
        if_imem_gnt_i = 1'b1;
        step();
        quiet();
        chk("pre_rst_wait", 32'(if_imem_req_o), 32'd0);
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_values("async_rst");
        step();
        step();
        rstn_i = 1'b1;
        exp_pc = BOOT;
        chk("reboot_req", 32'(if_imem_req_o), 32'd0);
        step();
        chk("reboot_req1",  32'(if_imem_req_o), 32'd1);
        chk("reboot_addr",  if_imem_addr_o,      BOOT);
        fetch(0, 0, 1'b0, $urandom);

        advance(1'b1, 32'hFFFF_FFFE, 0);
        chk("top_addr", if_imem_addr_o, 32'hFFFF_FFFC);
        fetch(0, 0, 1'b0, $urandom);
        advance(1'b0, 32'h0, 0);
        chk("wrap_addr", if_imem_addr_o, 32'h0000_0000);
        fetch(1, 1, 1'b0, $urandom);
        chk("wrap_pc", if_pc_o, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
